// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Raw per-state control word; handshake gating is applied by the top level.
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       retired;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational mapping from controller state to the raw datapath control word.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  // Moore decode: every state starts from all-zero controls and sets only what it needs.
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.ir_write  = 1'b1;
        cw.pc_write  = 1'b1;
        cw.alu_src_b = ALUSRCB_FOUR;
        cw.alu_op    = ALU_OP_ADD;
        cw.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        cw.alu_src_b = ALUSRCB_IMM_SH2;
        cw.alu_op    = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = ALUSRCB_B;
        cw.alu_op    = ALU_OP_FUNCT;
      end
      S_WB_R: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
        cw.retired   = 1'b1;
      end
      S_MEM_ADDR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = ALUSRCB_IMM;
        cw.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        cw.iord     = 1'b1;
        cw.mem_read = 1'b1;
      end
      S_WB_MEM: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.retired    = 1'b1;
      end
      S_MEM_WR: begin
        cw.iord      = 1'b1;
        cw.mem_write = 1'b1;
        cw.retired   = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = ALUSRCB_B;
        cw.alu_op        = ALU_OP_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_src        = PCSRC_ALUOUT;
        cw.retired       = 1'b1;
      end
      S_JUMP: begin
        cw.pc_write = 1'b1;
        cw.pc_src   = PCSRC_JUMP;
        cw.retired  = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: state sequencing, memory handshake gating, trap flag, retire counter.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        illegal,
  output logic        retired,
  output logic [31:0] instret
);

  state_t     state_q;
  state_t     state_d;
  ctrl_word_t cw;
  logic       illegal_q;

  ctrl_decode u_decode (
    .state (state_q),
    .cw    (cw)
  );

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: memory states hold until mem_ready, DECODE dispatches on opcode/funct.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (run) state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = (funct == FUNCT_ADD) ? S_EXEC_R : S_TRAP;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_WB_MEM:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
  end

  // Sticky illegal flag, set on the DECODE-to-TRAP transition and cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else if (state_q == S_DECODE && state_d == S_TRAP) illegal_q <= 1'b1;
  end

  // Retired-instruction counter; wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          instret <= 32'd0;
    else if (retired) instret <= instret + 32'd1;
  end

  assign ir_write      = cw.ir_write & mem_ready;
  assign pc_write      = cw.pc_write & (mem_ready | (state_q != S_FETCH));
  assign retired       = cw.retired & (mem_ready | (state_q != S_MEM_WR));
  assign pc_write_cond = cw.pc_write_cond;
  assign pc_en         = pc_write | (pc_write_cond & zero);
  assign iord          = cw.iord;
  assign mem_read      = cw.mem_read;
  assign mem_write     = cw.mem_write;
  assign reg_write     = cw.reg_write;
  assign reg_dst       = cw.reg_dst;
  assign mem_to_reg    = cw.mem_to_reg;
  assign alu_src_a     = cw.alu_src_a;
  assign alu_src_b     = cw.alu_src_b;
  assign alu_op        = cw.alu_op;
  assign pc_src        = cw.pc_src;
  assign illegal       = illegal_q;

endmodule
